// File: rtl/mux_share_arbiter_pkg.sv
// mux_share_arbiter_pkg: shared state encoding, select constants and counter widths
package mux_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SWITCH, GRANT_A, GRANT_B} state_e;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int MAX_HOLD_LIM = 15;
  localparam int HOLD_W = $clog2(MAX_HOLD_LIM + 1);
  localparam int DEAD_W = 2;
endpackage

// File: rtl/mux_share_datapath.sv
// mux_share_datapath: per-bit 2:1 transmission-gate mux with valid gating of the channel output
module mux_share_datapath #(
  parameter int WIDTH = 1
) (
  input  logic             s_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] mux_y;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign mux_y[i] = s_i ? b_i[i] : a_i[i];
  end
  assign y_o = valid_i ? mux_y : '0;
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin, hold-bounded owner of a shared 2:1 mux with break-before-make select
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4,
  parameter int DEAD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             valid
);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC == 0 ? 0 : DEAD_CYC - 1);

  state_e state_q, state_d;
  logic s_q, s_d, last_q, last_d, tgt_q, tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic own_b, req_own, req_oth, go, go_sel;

  assign own_b    = state_q == GRANT_B;
  assign req_own  = own_b ? req_b : req_a;
  assign req_oth  = own_b ? req_a : req_b;
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    last_d  = last_q;
    tgt_d   = tgt_q;
    go      = 1'b0;
    go_sel  = SEL_A;
    unique case (state_q)
      IDLE: begin
        go     = req_a | req_b;
        go_sel = (req_a & req_b) ? ~last_q : req_b;
      end
      SWITCH: begin
        if (dead_q == DEAD_LAST) state_d = tgt_q ? GRANT_B : GRANT_A;
        else dead_d = dead_q + 1'b1;
      end
      GRANT_A, GRANT_B: begin
        hold_d = hold_inc;
        if (!req_own || (hold_inc == HOLD_MAX && req_oth)) begin
          last_d  = own_b;
          hold_d  = '0;
          state_d = IDLE;
          go      = req_oth;
          go_sel  = ~own_b;
        end
      end
    endcase
    // a select change always passes through the dead interval unless it is configured away
    if (go) begin
      tgt_d  = go_sel;
      dead_d = '0;
      if (go_sel == s_q || DEAD_CYC == 0) state_d = go_sel ? GRANT_B : GRANT_A;
      else state_d = SWITCH;
      s_d = go_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= SEL_A;
      hold_q  <= '0;
      dead_q  <= '0;
      last_q  <= SEL_B;
      tgt_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
    end
  end

  assign gnt_a = state_q == GRANT_A;
  assign gnt_b = state_q == GRANT_B;
  assign valid = gnt_a | gnt_b;
  assign s     = s_q;

  mux_share_datapath #(.WIDTH(WIDTH)) u_dp (
    .s_i    (s_q),
    .valid_i(valid),
    .a_i    (a),
    .b_i    (b),
    .y_o    (y)
  );
endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Clocked controller that shares one 2:1 CMOS transmission-gate mux channel between two requesters, A (mux input a, s=0) and B (mux input b, s=1).
- Arbitrates with round-robin fairness and a bounded hold time.
- Drives the mux select with a break-before-make dead interval, so both transmission gates are never treated as conducting valid data during a select change.
- Sits between requester logic and the mux cell; the gated mux output is the shared channel.

Parameters:
- WIDTH, 1, data width of a, b, y. The mux is replicated per bit.
- MAX_HOLD, 4, grant cycles after which an owner is preempted if the other side is requesting. Range 1..15.
- DEAD_CYC, 1, dead cycles inserted on every select change. Range 0..3; 0 means no dead interval.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_a  input  1  requester A wants the channel
- req_b  input  1  requester B wants the channel
- a  input  WIDTH  requester A data
- b  input  WIDTH  requester B data
- gnt_a  output  1  A owns the channel this cycle
- gnt_b  output  1  B owns the channel this cycle
- s  output  1  mux select (0 = a, 1 = b), registered
- y  output  WIDTH  channel data; equals the mux output while valid is high, else 0
- valid  output  1  y carries owner data this cycle

Behaviour:
- Synchronous reset, active-high. Values after the reset edge:
  - state=IDLE; s=0; gnt_a=gnt_b=0; valid=0; y=0; hold_cnt=0; dead_cnt=0.
  - last_served=B, so A wins the first tie.
- Reset asserted mid-grant or mid-switch: every output returns to its reset value at that edge. No partial completion.
- States and transitions:
  - IDLE
    - No req: stay.
    - One req: that side is the target.
    - Both req: target = side != last_served.
    - If target's select equals current s, go to GRANT_x next cycle with no dead interval.
    - Otherwise go to SWITCH: s takes the target value at the same edge.
  - SWITCH
    - gnt_a=gnt_b=0, valid=0.
    - dead_cnt counts DEAD_CYC cycles, then GRANT_target.
    - DEAD_CYC=0 skips this state.
    - Target is latched at entry. If the target's req drops during SWITCH, still enter GRANT_target; the exit rule below releases it after one cycle.
  - GRANT_A / GRANT_B
    - gnt_x=1, valid=1, y = (s ? b : a), combinational from the mux.
    - hold_cnt increments each grant cycle and saturates at MAX_HOLD.
    - Exit condition: req_x low, OR (hold_cnt==MAX_HOLD AND other req high).
    - On exit: last_served=x and hold_cnt=0.
    - Exit with other req high: go to SWITCH with s toggled.
    - Exit with other req low: go to IDLE; s holds.
    - Owner still requesting and other idle: grant persists indefinitely.
- Simultaneous req drop and hold expiry: same outcome as the exit rule above.
- Latency:
  - Request from IDLE with s already matching: gnt one cycle after req is sampled.
  - Request needing a select change: gnt 1+DEAD_CYC cycles after req is sampled.
- Invariants:
  - gnt_a and gnt_b are never both high.
  - valid == gnt_a | gnt_b.
  - s never changes while valid=1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SWITCH, GRANT_A, GRANT_B};
  - select constants SEL_A=0, SEL_B=1;
  - width of hold_cnt, derived from MAX_HOLD max of 15 (4 bits).
- One sub-module, mux_share_datapath: WIDTH-bit array of transmission-gate 2:1 muxes plus valid gating of y. The FSM stays in the top.

Test Plan:
1. rst=1 for 2 cycles with req_a=req_b=1 → s=0, gnt=00, valid=0, y=0. Release → gnt_a=1 next cycle (tie, last_served=B). No dead cycle since s already 0.
2. req_a only, a=1 for 10 cycles (MAX_HOLD=4) → gnt_a held all 10 cycles, y=1, s stays 0; no preemption.
3. req_a and req_b held, a=0, b=1, MAX_HOLD=4, DEAD_CYC=1 → repeating 4 gnt_a, 1 dead, 4 gnt_b, 1 dead cycles. y=0 during A, y=1 during B, y=0 in dead cycles. s flips only at dead-cycle entry.
4. During GRANT_B, drop req_b while req_a=1 → next cycle SWITCH (s=0, valid=0), then gnt_a. With DEAD_CYC=0, gnt_a arrives directly the cycle after the drop.
5. Assert rst during SWITCH and again during GRANT_B → at that edge s=0, gnt=00, valid=0. First tie afterwards goes to A.
6. Pulse req_b for one cycle from IDLE (s=0, DEAD_CYC=2) → SWITCH 2 cycles, one gnt_b cycle, then IDLE with s=1. A subsequent req_b gets gnt_b one cycle later with no dead interval.
